// File: rtl/w5500_tx_writer.sv
// w5500_tx_writer: buffers forwarded 16-bit words and commits each packet to a W5500 socket TX buffer over SPI mode 0.
// Optional feature macro W5500_TX_PTR_READ_EN: read Sn_TX_WR from the chip before each packet instead of trusting the local copy.
module w5500_tx_writer #(
  parameter int SCLK_DIV  = 2,
  parameter int SOCKET    = 0,
  parameter int BUF_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_word,
  input  logic        i_word_valid,
  output logic        o_word_ready,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_spi_sclk,
  output logic        o_spi_mosi,
  output logic        o_spi_cs_n,
  input  logic        i_spi_miso
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]  C_TXBUF  = {5'(SOCKET * 4 + 2), 3'b100};
  localparam logic [7:0]  C_REG_WR = {5'(SOCKET * 4 + 1), 3'b100};
  localparam logic [7:0]  C_REG_RD = {5'(SOCKET * 4 + 1), 3'b000};
  localparam logic [15:0] C_HALF   = 16'(SCLK_DIV - 1);
  localparam logic [15:0] C_GAP    = 16'(2 * SCLK_DIV - 1);
  typedef enum logic [3:0] {S_IDLE, S_RD, S_GAPR, S_HDR, S_DATA, S_GAP1, S_PTR, S_GAP2, S_CMD, S_DONE} state_t;
  state_t         r_st;
  logic [15:0]    r_mem [BUF_DEPTH];
  logic [AW-1:0]  r_wr, r_rd;
  logic [AW:0]    r_cnt, r_n;
  logic           r_flush, r_busy, r_done, r_cs_n, r_sclk, r_tail;
  logic [15:0]    r_tx_ptr, r_rx, r_div;
  logic [7:0]     r_sh, r_idx;
  logic [2:0]     r_bit;
  logic           w_wr, w_pop, w_last, w_data_frame;
  logic [7:0]     w_nidx, w_byte, w_last_idx;
  logic [15:0]    w_rd_word, w_new_ptr;
  assign o_word_ready = !r_cnt[AW] && !r_flush && !r_busy;
  assign w_wr         = i_word_valid && o_word_ready;
  assign w_data_frame = r_st == S_HDR || r_st == S_DATA;
  assign w_nidx       = r_idx + 8'd1;
  assign w_rd_word    = r_mem[r_rd];
  assign w_new_ptr    = r_tx_ptr + 16'({r_n, 1'b0});
  assign w_last_idx   = w_data_frame ? 8'({r_n, 1'b0}) + 8'd2 : r_st == S_CMD ? 8'd3 : 8'd4;
  assign w_last       = r_idx == w_last_idx;
  assign w_pop        = r_st == S_DATA && !w_nidx[0];
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_spi_sclk   = r_sclk;
  assign o_spi_mosi   = r_sh[7];
  assign o_spi_cs_n   = r_cs_n;
  // next byte to shift out in the current frame, selected by frame type and byte index
  always_comb begin
    w_byte = 8'h00;
    if (w_data_frame) w_byte = w_nidx == 8'd1 ? r_tx_ptr[7:0] : w_nidx == 8'd2 ? C_TXBUF : w_nidx[0] ? w_rd_word[15:8] : w_rd_word[7:0];
    else if (r_st == S_PTR) w_byte = w_nidx == 8'd1 ? 8'h24 : w_nidx == 8'd2 ? C_REG_WR : w_nidx == 8'd3 ? w_new_ptr[15:8] : w_new_ptr[7:0];
    else if (r_st == S_CMD) w_byte = w_nidx == 8'd1 ? 8'h01 : w_nidx == 8'd2 ? C_REG_WR : 8'h20;
    else if (r_st == S_RD) w_byte = w_nidx == 8'd1 ? 8'h24 : w_nidx == 8'd2 ? C_REG_RD : 8'h00;
  end
  // FIFO storage; occupancy is tracked by the controller so the array needs no reset
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr] <= i_word;
  end
  // packet controller: FIFO pointers, flush capture and the SPI frame sequencer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st <= S_IDLE; r_wr <= '0; r_rd <= '0; r_cnt <= '0; r_n <= '0;
      r_flush <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0; r_cs_n <= 1'b1; r_sclk <= 1'b0; r_tail <= 1'b0;
      r_tx_ptr <= '0; r_rx <= '0; r_div <= '0; r_sh <= '0; r_idx <= '0; r_bit <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_wr) begin r_wr <= r_wr + AW'(1); r_cnt <= r_cnt + CW'(1); end
      if (i_flush && !r_busy) r_flush <= 1'b1;
      case (r_st)
        S_IDLE: if (r_flush) begin
          if (r_cnt == '0) begin r_done <= 1'b1; r_flush <= 1'b0; end
          else begin
            r_n <= r_cnt; r_busy <= 1'b1; r_cs_n <= 1'b0; r_idx <= '0; r_bit <= '0; r_div <= C_HALF;
`ifdef W5500_TX_PTR_READ_EN
            r_st <= S_RD; r_sh <= 8'h00;
`else
            r_st <= S_HDR; r_sh <= r_tx_ptr[15:8];
`endif
          end
        end
        S_RD, S_HDR, S_DATA, S_PTR, S_CMD:
          if (r_div != '0) r_div <= r_div - 16'd1;
          else if (r_tail) begin
            r_tail <= 1'b0; r_cs_n <= 1'b1; r_div <= C_GAP; r_sh <= '0;
            r_st <= r_st == S_RD ? S_GAPR : r_st == S_DATA ? S_GAP1 : r_st == S_PTR ? S_GAP2 : S_DONE;
            if (r_st == S_RD) r_tx_ptr <= r_rx;
          end else if (!r_sclk) begin
            r_sclk <= 1'b1; r_div <= C_HALF;
            if (r_st == S_RD && r_idx >= 8'd3) r_rx <= {r_rx[14:0], i_spi_miso};
          end else begin
            r_sclk <= 1'b0; r_div <= C_HALF;
            if (r_bit != 3'd7) begin r_bit <= r_bit + 3'd1; r_sh <= {r_sh[6:0], 1'b0}; end
            else if (w_last) r_tail <= 1'b1;
            else begin
              r_bit <= '0; r_idx <= w_nidx; r_sh <= w_byte;
              if (r_st == S_HDR && w_nidx == 8'd3) r_st <= S_DATA;
              if (w_pop) begin r_rd <= r_rd + AW'(1); r_cnt <= r_cnt - CW'(1); end
            end
          end
        S_GAPR, S_GAP1, S_GAP2:
          if (r_div != '0) r_div <= r_div - 16'd1;
          else begin
            r_cs_n <= 1'b0; r_idx <= '0; r_bit <= '0; r_div <= C_HALF;
            r_sh <= r_st == S_GAPR ? r_tx_ptr[15:8] : 8'h00;
            r_st <= r_st == S_GAPR ? S_HDR : r_st == S_GAP1 ? S_PTR : S_CMD;
          end
        S_DONE: begin
          r_tx_ptr <= w_new_ptr; r_done <= 1'b1; r_busy <= 1'b0; r_flush <= 1'b0; r_st <= S_IDLE;
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_w5500_tx_writer.sv
// tb_w5500_tx_writer: directed packets with a byte/frame scoreboard fed by stimulus and drained by an SPI monitor.
module tb_w5500_tx_writer;
  localparam int DIV = 2;
  logic clk = 1'b0, rst = 1'b1, word_valid = 1'b0, flush = 1'b0, miso = 1'b0;
  logic [15:0] word = 16'h0000;
  logic word_ready, busy, done, sclk, mosi, cs_n;
  int n_chk = 0, n_err = 0, exp_done = 0, n_bytes = 0;
  bit abort = 1'b0;
  logic [7:0] q_byte [$];
  int q_len [$];
  logic [15:0] pkt [$];
  logic [7:0] t2 [16] = '{8'h00, 8'h00, 8'h14, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h24, 8'h0C, 8'h00, 8'h04, 8'h00, 8'h01, 8'h0C, 8'h20};
  always #5 clk = ~clk;
  w5500_tx_writer #(.SCLK_DIV(DIV), .SOCKET(0), .BUF_DEPTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_word(word), .i_word_valid(word_valid), .o_word_ready(word_ready),
    .i_flush(flush), .o_busy(busy), .o_done(done), .o_spi_sclk(sclk), .o_spi_mosi(mosi),
    .o_spi_cs_n(cs_n), .i_spi_miso(miso)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic expect_pkt(input logic [15:0] ptr);
    logic [15:0] np;
    np = ptr + 16'(2 * pkt.size());
    q_byte.push_back(ptr[15:8]); q_byte.push_back(ptr[7:0]); q_byte.push_back(8'h14);
    foreach (pkt[i]) begin q_byte.push_back(pkt[i][15:8]); q_byte.push_back(pkt[i][7:0]); end
    q_len.push_back(3 + 2 * pkt.size());
    q_byte.push_back(8'h00); q_byte.push_back(8'h24); q_byte.push_back(8'h0C); q_byte.push_back(np[15:8]); q_byte.push_back(np[7:0]);
    q_len.push_back(5);
    q_byte.push_back(8'h00); q_byte.push_back(8'h01); q_byte.push_back(8'h0C); q_byte.push_back(8'h20);
    q_len.push_back(4);
    exp_done++;
  endtask
  task automatic send_word(input logic [15:0] w);
    word = w; word_valid = 1'b1;
    for (int k = 0; k < 3000 && !word_ready; k++) @(negedge clk);
    chk("word_accept_ready", int'(word_ready), 1);
    @(negedge clk);
    word_valid = 1'b0;
  endtask
  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask
  task automatic send_pkt();
    foreach (pkt[i]) send_word(pkt[i]);
    pulse_flush();
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 4000 && (exp_done != 0 || q_byte.size() != 0); k++) @(negedge clk);
    chk("pkt_complete_pending", exp_done + q_byte.size(), 0);
  endtask
  // SPI slave model and done monitor: decodes MOSI on rising SCLK and checks framing timing
  logic p_sclk = 1'b0, p_cs = 1'b1, rose = 1'b0, mid_pkt = 1'b0;
  logic [7:0] sr = 8'h00;
  int nbits = 0, lead = 0, tail = 0, gap = 0;
  always @(negedge clk) begin
    if (done) begin
      if (exp_done == 0) chk("done_unexpected", 1, 0);
      else begin chk("done_pulse", int'(done), 1); exp_done--; end
      mid_pkt = 1'b0;
    end
    if (p_cs && !cs_n) begin
      if (mid_pkt) chk("cs_gap_cycles", gap, 2 * DIV);
      mid_pkt = 1'b1; nbits = 0; lead = 0; tail = 0; rose = 1'b0;
    end
    if (!cs_n) begin
      if (!p_sclk && sclk) begin
        if (!rose) chk("cs_lead_cycles", lead, DIV);
        rose = 1'b1;
        sr = {sr[6:0], mosi};
        nbits++;
        if (nbits % 8 == 0) begin
          n_bytes++;
          if (q_byte.size() == 0) chk("mosi_byte_unexpected", int'(sr), -1);
          else chk("mosi_byte", int'(sr), int'(q_byte.pop_front()));
        end
      end
      if (p_sclk && !sclk) tail = 0;
      if (!sclk) begin
        if (!rose) lead++;
        else tail++;
      end
    end
    if (!p_cs && cs_n) begin
      if (abort) begin abort = 1'b0; mid_pkt = 1'b0; end
      else begin
        chk("frame_bits_mod8", nbits % 8, 0);
        chk("cs_tail_cycles", tail, DIV);
        if (q_len.size() == 0) chk("frame_unexpected", nbits / 8, 0);
        else chk("frame_len", nbits / 8, q_len.pop_front());
      end
      gap = 0;
    end
    if (cs_n) gap++;
    p_sclk = sclk;
    p_cs = cs_n;
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(word_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    foreach (t2[i]) q_byte.push_back(t2[i]);
    q_len.push_back(7); q_len.push_back(5); q_len.push_back(4);
    exp_done++;
    send_word(16'h1234);
    send_word(16'hABCD);
    pulse_flush();
    chk("ready_flush_pending", int'(word_ready), 0);
    wait_idle();
    exp_done++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("empty_flush_done", int'(done), 1);
    chk("empty_flush_busy", int'(busy), 0);
    chk("empty_flush_cs_n", int'(cs_n), 1);
    @(negedge clk);
    chk("empty_flush_done_width", int'(done), 0);
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back({8'(i), 8'(8'hF0 ^ 8'(i))});
    expect_pkt(16'h0004);
    foreach (pkt[i]) send_word(pkt[i]);
    chk("ready_full", int'(word_ready), 0);
    word = 16'h7777; word_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_full_held", int'(word_ready), 0);
    pulse_flush();
    for (int k = 0; k < 3000 && !word_ready; k++) @(negedge clk);
    chk("held_word_ready", int'(word_ready), 1);
    pkt.delete();
    pkt.push_back(16'h7777);
    expect_pkt(16'h0024);
    @(negedge clk);
    word_valid = 1'b0;
    pulse_flush();
    wait_idle();
    pkt.delete();
    pkt.push_back(16'h1111); pkt.push_back(16'h2222); pkt.push_back(16'h3333); pkt.push_back(16'h4444);
    expect_pkt(16'h0026);
    n_bytes = 0;
    send_pkt();
    for (int k = 0; k < 1000 && n_bytes < 5; k++) @(negedge clk);
    chk("reached_data_phase", int'(n_bytes >= 5), 1);
    abort = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cs_n", int'(cs_n), 1);
    chk("rst_mid_busy", int'(busy), 0);
    rst = 1'b0;
    q_byte.delete(); q_len.delete(); exp_done = 0;
    repeat (60) @(negedge clk);
    chk("rst_mid_no_done", exp_done, 0);
    pkt.delete();
    pkt.push_back(16'h5A5A); pkt.push_back(16'hC3C3);
    expect_pkt(16'h0000);
    send_pkt();
    wait_idle();
    force dut.r_tx_ptr = 16'hFFFE;
    pkt.delete();
    pkt.push_back(16'h0102); pkt.push_back(16'h0304);
    expect_pkt(16'hFFFE);
    send_pkt();
    wait_idle();
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q_byte.size() + q_len.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
